// File: rtl/vga_pattern_sequencer.sv
// Test-pattern select sequencer: debounced button or auto-cycle advances the pattern ID,
// with every change held off until the next falling edge of vsync (frame boundary).
module vga_pattern_sequencer #(
   parameter int unsigned PATTERN_WIDTH   = 4,
   parameter int unsigned NUM_PATTERNS    = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned AUTO_FRAMES     = 120
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_vsync,
   input  logic                     i_btn_next,
   input  logic                     i_auto_en,
   output logic [PATTERN_WIDTH-1:0] o_pattern,
   output logic                     o_pattern_chg,
   output logic                     o_req_pending
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned FrmW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

   localparam logic [CntW-1:0]          CntLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [FrmW-1:0]          FrmLast = FrmW'(AUTO_FRAMES - 1);
   localparam logic [PATTERN_WIDTH-1:0] PatLast = PATTERN_WIDTH'(NUM_PATTERNS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StPressChk,
      StHeld,
      StRelChk
   } deb_state_e;

   deb_state_e                state_q, state_d;
   logic                      btn_meta_q, btn_s_q;
   logic                      vs_d_q;
   logic [CntW-1:0]           cnt_q, cnt_d, cnt_inc;
   logic                      pending_q, pending_d;
   logic [FrmW-1:0]           frame_cnt_q, frame_cnt_d;
   logic [PATTERN_WIDTH-1:0]  pattern_q, pattern_d;
   logic                      chg_q;

   logic                      press_acc;
   logic                      frame_edge;
   logic                      auto_adv;
   logic                      advance;

   assign cnt_inc = cnt_q + CntW'(1);

   // Debounce: a level is accepted once btn_s has held it for DEBOUNCE_CYCLES clocks.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_acc = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (btn_s_q) begin
               state_d = StPressChk;
               cnt_d   = '0;
            end
         end
         StPressChk: begin
            if (!btn_s_q) begin
               state_d = StIdle;
            end else if (cnt_inc >= CntLast) begin
               state_d   = StHeld;
               cnt_d     = '0;
               press_acc = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StHeld: begin
            if (!btn_s_q) begin
               state_d = StRelChk;
               cnt_d   = '0;
            end
         end
         StRelChk: begin
            if (btn_s_q) begin
               state_d = StHeld;
            end else if (cnt_inc >= CntLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   assign frame_edge = vs_d_q & ~i_vsync;
   assign auto_adv   = frame_edge & i_auto_en & (frame_cnt_q == FrmLast);
   assign advance    = frame_edge & (pending_q | auto_adv);

   always_comb begin
      // A new acceptance in the same cycle as an advance survives for the next frame.
      pending_d = pending_q;
      if (press_acc) begin
         pending_d = 1'b1;
      end else if (advance) begin
         pending_d = 1'b0;
      end

      frame_cnt_d = frame_cnt_q;
      if (!i_auto_en || advance) begin
         frame_cnt_d = '0;
      end else if (frame_edge) begin
         frame_cnt_d = frame_cnt_q + FrmW'(1);
      end

      pattern_d = pattern_q;
      if (advance) begin
         pattern_d = (pattern_q == PatLast) ? '0 : pattern_q + PATTERN_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         btn_meta_q  <= 1'b0;
         btn_s_q     <= 1'b0;
         vs_d_q      <= i_vsync;
         state_q     <= StIdle;
         cnt_q       <= '0;
         pending_q   <= 1'b0;
         frame_cnt_q <= '0;
         pattern_q   <= '0;
         chg_q       <= 1'b0;
      end else begin
         btn_meta_q  <= i_btn_next;
         btn_s_q     <= btn_meta_q;
         vs_d_q      <= i_vsync;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         frame_cnt_q <= frame_cnt_d;
         pattern_q   <= pattern_d;
         chg_q       <= advance;
      end
   end

   assign o_pattern     = pattern_q;
   assign o_pattern_chg = chg_q;
   assign o_req_pending = pending_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed bench for vga_pattern_sequencer: phase table for debounce/boundary timing plus
// hand-written frame sequences for auto-cycling, press/auto coincidence and mid-request reset.
module tb_vga_pattern_sequencer;

   localparam int unsigned PW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          vsync;
   logic          btn;
   logic          auto_en;
   logic [PW-1:0] pattern;
   logic          chg;
   logic          pend;

   int unsigned   n_vec = 0;
   int unsigned   n_err = 0;
   int unsigned   chg_seen = 0;

   always #5 clk = ~clk;

   vga_pattern_sequencer #(
      .PATTERN_WIDTH  (PW),
      .NUM_PATTERNS   (3),
      .DEBOUNCE_CYCLES(4),
      .AUTO_FRAMES    (3)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_vsync      (vsync),
      .i_btn_next   (btn),
      .i_auto_en    (auto_en),
      .o_pattern    (pattern),
      .o_pattern_chg(chg),
      .o_req_pending(pend)
   );

   // One phase: inputs held for 'cycles' clocks, then outputs compared.
   typedef struct {
      logic          rst;
      logic          vsync;
      logic          btn;
      logic          auto_en;
      int unsigned   cycles;
      logic [PW-1:0] exp_pat;
      logic          exp_pend;
      int unsigned   exp_chg;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic vs, input logic b, input logic a,
                               input int unsigned c, input int unsigned p, input logic pe,
                               input int unsigned ch);
      vec_t v;
      v.rst      = r;
      v.vsync    = vs;
      v.btn      = b;
      v.auto_en  = a;
      v.cycles   = c;
      v.exp_pat  = PW'(p);
      v.exp_pend = pe;
      v.exp_chg  = ch;
      return v;
   endfunction

   task automatic step(input int unsigned n);
      for (int i = 0; i < int'(n); i++) begin
         @(posedge clk);
         #1;
         if (chg === 1'b1) chg_seen++;
      end
   endtask

   task automatic check_pat(input string what, input logic [PW-1:0] exp);
      n_vec++;
      if (pattern !== exp) begin
         n_err++;
         $display("FAIL %s: o_pattern=%0d, expected %0d", what, pattern, exp);
      end
   endtask

   task automatic check_pend(input string what, input logic exp);
      n_vec++;
      if (pend !== exp) begin
         n_err++;
         $display("FAIL %s: o_req_pending=%b, expected %b", what, pend, exp);
      end
   endtask

   task automatic check_chg(input string what, input int unsigned exp);
      n_vec++;
      if (chg_seen != exp) begin
         n_err++;
         $display("FAIL %s: o_pattern_chg pulses=%0d, expected %0d", what, chg_seen, exp);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      vsync = 1'b0;
      btn   = 1'b0;
      step(2);
      rst   = 1'b0;
   endtask

   task automatic run_frame(input string what, input int unsigned exp_p,
                            input int unsigned exp_c);
      chg_seen = 0;
      vsync    = 1'b1;
      step(12);
      vsync    = 1'b0;
      step(4);
      check_pat(what, PW'(exp_p));
      check_chg(what, exp_c);
   endtask

   initial begin
      rst     = 1'b1;
      vsync   = 1'b0;
      btn     = 1'b0;
      auto_en = 1'b0;

      // Reset with vsync low, then five idle frames.
      tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0));
      for (int f = 0; f < 5; f++) begin
         tbl.push_back(mk(0, 1, 0, 0, 12, 0, 0, 0));
         tbl.push_back(mk(0, 0, 0, 0, 4, 0, 0, 0));
      end
      // Two-clock bounce is rejected.
      tbl.push_back(mk(0, 1, 1, 0, 2, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 10, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 4, 0, 0, 0));
      // Held press: pending after 2 sync + 4 debounce clocks, applied at the vsync fall.
      tbl.push_back(mk(0, 1, 1, 0, 5, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 0, 6, 0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 3, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 7, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 5, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 4, 1, 0, 0));

      foreach (tbl[k]) begin
         rst      = tbl[k].rst;
         vsync    = tbl[k].vsync;
         btn      = tbl[k].btn;
         auto_en  = tbl[k].auto_en;
         chg_seen = 0;
         step(tbl[k].cycles);
         check_pat($sformatf("vec%0d pattern", k), tbl[k].exp_pat);
         check_pend($sformatf("vec%0d pending", k), tbl[k].exp_pend);
         check_chg($sformatf("vec%0d chg", k), tbl[k].exp_chg);
      end

      // Auto cycling every 3 frames, including the wrap 2 -> 0.
      auto_en = 1'b1;
      do_reset();
      check_pat("auto reset", '0);
      for (int f = 1; f <= 9; f++) begin
         run_frame($sformatf("auto frame%0d", f), (f / 3) % 3, (f % 3 == 0) ? 1 : 0);
      end

      // Press accepted in the frame whose boundary is also an auto advance.
      do_reset();
      run_frame("coinc frame1", 0, 0);
      run_frame("coinc frame2", 0, 0);
      chg_seen = 0;
      vsync    = 1'b1;
      btn      = 1'b1;
      step(8);
      btn      = 1'b0;
      step(4);
      check_pend("coinc pending set", 1'b1);
      vsync    = 1'b0;
      step(4);
      check_pat("coinc frame3", PW'(1));
      check_chg("coinc frame3", 1);
      check_pend("coinc pending cleared", 1'b0);
      run_frame("coinc frame4", 1, 0);
      run_frame("coinc frame5", 1, 0);
      run_frame("coinc frame6", 2, 1);

      // Reset while a request is pending discards it.
      auto_en = 1'b0;
      vsync   = 1'b1;
      btn     = 1'b1;
      step(8);
      btn     = 1'b0;
      step(2);
      check_pend("rst pending set", 1'b1);
      check_pat("rst before", PW'(2));
      rst     = 1'b1;
      step(1);
      rst     = 1'b0;
      check_pat("rst pattern", '0);
      check_pend("rst pending", 1'b0);
      chg_seen = 0;
      step(5);
      vsync    = 1'b0;
      step(4);
      check_pat("rst boundary pattern", '0);
      check_pend("rst boundary pending", 1'b0);
      check_chg("rst boundary chg", 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
